seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 13 +
 rtl/seq_sat_cnt.sv | 34 +++
 rtl/seq_detect_param.sv | 101 ++++++++++
 tb/tb_seq_detect_param.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types for the parameterised serial pattern detector:
// the FILL/RUN state encoding and the overlap mode constants.
package seq_detect_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

endpackage

// File: rtl/seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module seq_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with overlapping/non-overlapping mode.
// Define SEQDET_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = 4'b1001,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             ovl_in,
`ifdef SEQDET_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             dout
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    if ((PAT_W < 2) || (PAT_W > 16) || (CNT_W < 1)) begin : g_bad_param
        $error("seq_detect_param: PAT_W must be 2..16 and CNT_W >= 1");
    end

    seq_state_e        state_q;
    logic [PAT_W-2:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0]  pat_q;
    logic              mode_q;
    logic              dout_q;

    logic [PAT_W-1:0]  window;
    logic [PAT_W-2:0]  hist_d;
    logic              accept;
    logic              match_d;

    // The incoming bit completes the window; bit PAT_W-1 is the oldest.
    assign window  = {hist_q, d};
    assign hist_d  = window[PAT_W-2:0];
    assign accept  = en & ~load;
    assign match_d = accept && (state_q == RUN) && (window == pat_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PAT;
            mode_q  <= MODE_NONOVL;
            dout_q  <= 1'b0;
        end else begin
            dout_q <= match_d;
            if (load) begin
                pat_q   <= pat_in;
                mode_q  <= ovl_in;
                hist_q  <= '0;
                fill_q  <= '0;
                state_q <= FILL;
            end else if (accept) begin
                hist_q <= hist_d;
                case (state_q)
                    FILL: begin
                        fill_q <= fill_q + 1'b1;
                        if (fill_q == FILL_MAX - 1'b1) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        // Non-overlapping: the matched bits must all be refilled.
                        if (match_d && (mode_q == MODE_NONOVL)) begin
                            fill_q  <= '0;
                            state_q <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign dout = dout_q;

`ifdef SEQDET_CNT_EN
    seq_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .inc(dout_q),
        .cnt(match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: default 4-bit detector (A) and a 3-bit "111" detector with a 2-bit counter (B).
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_en = 1'b0, a_d = 1'b0, a_load = 1'b0, a_ovl = 1'b0, a_clr = 1'b0;
    logic [3:0] a_pat = 4'b0000;
    logic       dout_a;
    logic [7:0] cnt_a;

    logic       b_en = 1'b0, b_d = 1'b0, b_load = 1'b0, b_ovl = 1'b0, b_clr = 1'b0;
    logic [2:0] b_pat = 3'b000;
    logic       dout_b;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W(4), .DEF_PAT(4'b1001), .CNT_W(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .d(a_d), .load(a_load),
        .pat_in(a_pat), .ovl_in(a_ovl),
`ifdef SEQDET_CNT_EN
        .cnt_clr(a_clr), .match_cnt(cnt_a),
`endif
        .dout(dout_a)
    );

    seq_detect_param #(
        .PAT_W(3), .DEF_PAT(3'b111), .CNT_W(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .d(b_d), .load(b_load),
        .pat_in(b_pat), .ovl_in(b_ovl),
`ifdef SEQDET_CNT_EN
        .cnt_clr(b_clr), .match_cnt(cnt_b),
`endif
        .dout(dout_b)
    );

`ifndef SEQDET_CNT_EN
    assign cnt_a = 8'd0;
    assign cnt_b = 2'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed n bits MSB-first to one DUT; exp holds the dout expected after each bit.
    task automatic run_bits(input bit sel_b, input string tag, input logic [15:0] bits,
                            input logic [15:0] exp, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (sel_b) begin b_en = 1'b1; b_load = 1'b0; b_d = bits[i]; end
            else       begin a_en = 1'b1; a_load = 1'b0; a_d = bits[i]; end
            @(posedge clk); #1;
            chk($sformatf("%s_bit%0d", tag, n - i), sel_b ? dout_b : dout_a, exp[i]);
            $display("%s bit%0d d=%0b dout_a=%0b dout_b=%0b", tag, n - i, bits[i], dout_a, dout_b);
        end
        a_en = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic load_a(input string tag, input logic [3:0] pat, input logic ovl, input logic dv);
        a_load = 1'b1; a_en = 1'b1; a_d = dv; a_pat = pat; a_ovl = ovl;
        @(posedge clk); #1;
        a_load = 1'b0; a_en = 1'b0;
        chk(tag, dout_a, 1'b0);
        $display("%s load pat=%b ovl=%0b dout_a=%0b", tag, pat, ovl, dout_a);
    endtask

    task automatic idle(input string tag, input logic exp_a);
        a_en = 1'b0; a_d = 1'b1; b_en = 1'b0; b_d = 1'b1;
        @(posedge clk); #1;
        chk(tag, dout_a, exp_a);
        $display("%s idle dout_a=%0b cnt_b=%0d", tag, dout_a, cnt_b);
    endtask

    initial begin
        #1;
        chk("reset_dout_a", dout_a, 1'b0);
        chk("reset_dout_b", dout_b, 1'b0);
`ifdef SEQDET_CNT_EN
        chk("reset_cnt_a", cnt_a, 8'd0);
        chk("reset_cnt_b", cnt_b, 2'd0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Non-overlapping default pattern: the "1" ending the first match is not reused.
        run_bits(1'b0, "nonovl", 16'b1001001, 16'b0001000, 7);

        // Overlapping mode: second match shares the middle "1".
        load_a("ld_ovl", 4'b1001, 1'b1, 1'b0);
        run_bits(1'b0, "ovl", 16'b1001001, 16'b0001001, 7);

        // Idle cycles hold the partial history.
        load_a("ld_nonovl", 4'b1001, 1'b0, 1'b0);
        run_bits(1'b0, "gap_pre", 16'b100, 16'b000, 3);
        idle("gap_idle1", 1'b0);
        idle("gap_idle2", 1'b0);
        idle("gap_idle3", 1'b0);
        run_bits(1'b0, "gap_last", 16'b1, 16'b1, 1);
        idle("gap_after", 1'b0);

        // Load beats a pending match and discards its d bit.
        run_bits(1'b0, "ldpri_pre", 16'b100, 16'b000, 3);
        load_a("ldpri_load", 4'b0110, 1'b1, 1'b1);
        run_bits(1'b0, "newpat", 16'b0110110, 16'b0001001, 7);

        // Asynchronous reset clears dout without a clock edge and restores defaults.
        rst = 1'b1;
        #1;
        chk("async_rst_dout", dout_a, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        run_bits(1'b0, "after_rst", 16'b1001001, 16'b0001000, 7);

        // 3-bit "111" detector, non-overlapping.
        run_bits(1'b1, "p3_ones", 16'b111111, 16'b001001, 6);
        idle("p3_idle", 1'b0);
`ifdef SEQDET_CNT_EN
        chk("p3_cnt2", cnt_b, 2'd2);
`endif
        run_bits(1'b1, "p3_more", 16'b111111111, 16'b001001001, 9);
        idle("p3_idle2", 1'b0);
`ifdef SEQDET_CNT_EN
        chk("p3_cnt_sat", cnt_b, 2'd3);
`endif
        run_bits(1'b1, "p3_last", 16'b111, 16'b001, 3);
        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        chk("p3_clr_dout", dout_b, 1'b0);
`ifdef SEQDET_CNT_EN
        chk("p3_clr_wins", cnt_b, 2'd0);
`endif
        idle("p3_idle3", 1'b0);
`ifdef SEQDET_CNT_EN
        chk("p3_cnt_after_clr", cnt_b, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
